// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: splits each access into BUS_BYTES-wide ready/valid beats and extends load data.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses instead of issuing them byte-addressed.
module mem_access_unit #(
  parameter int ADDR_W    = 32,
  parameter int BUS_BYTES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic                   op_load,
  input  logic [1:0]             op_size,
  input  logic                   op_unsigned,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [31:0]            wdata,
  output logic                   stall_o,
  output logic                   done_o,
  output logic [31:0]            rdata_o,
  output logic                   misalign_o,
  output logic                   mc_req,
  output logic                   mc_we,
  output logic [ADDR_W-1:0]      mc_addr,
  output logic [8*BUS_BYTES-1:0] mc_wdata,
  output logic [BUS_BYTES-1:0]   mc_wstrb,
  input  logic                   mc_ready,
  input  logic                   mc_rvalid,
  input  logic [8*BUS_BYTES-1:0] mc_rdata
);

  localparam int unsigned BB = BUS_BYTES;

`ifdef MEM_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t                 state;
  logic                   load_l;
  logic                   uns_l;
  logic [1:0]             size_l;
  logic [ADDR_W-1:0]      addr_l;
  logic [31:0]            wdata_l;
  logic [2:0]             beat;
  logic [31:0]            asm_q;
  logic                   flushed;

  logic                   nxt_ld;
  logic [1:0]             nxt_size;
  logic [ADDR_W-1:0]      nxt_base;
  logic [31:0]            nxt_wd;
  logic [2:0]             nxt_k;
  logic [ADDR_W-1:0]      nxt_addr;
  logic [8*BUS_BYTES-1:0] nxt_wdata;
  logic [BUS_BYTES-1:0]   nxt_strb;
  logic [31:0]            asm_next;
  logic                   is_last;
  logic                   trap;

  function automatic int unsigned nbytes(input logic [1:0] size);
    case (size)
      2'd0:    return 1;
      2'd1:    return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [2:0] last_beat(input logic [1:0] size);
    return 3'((nbytes(size) + BB - 1) / BB - 1);
  endfunction

  function automatic logic [BUS_BYTES-1:0] lane_en(input logic [1:0] size, input logic [2:0] k);
    logic [BUS_BYTES-1:0] en;
    en = '0;
    for (int unsigned j = 0; j < BB; j++)
      en[j] = (32'(k) * BB + j) < nbytes(size);
    return en;
  endfunction

  function automatic logic [8*BUS_BYTES-1:0] lane_data(input logic [31:0] wd, input logic [1:0] size,
                                                      input logic [2:0] k);
    logic [8*BUS_BYTES-1:0] d;
    int unsigned            b;
    d = '0;
    for (int unsigned j = 0; j < BB; j++) begin
      b = 32'(k) * BB + j;
      if (b < nbytes(size)) d[8*j +: 8] = wd[8*b[1:0] +: 8];
    end
    return d;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] size, input logic uns);
    case (size)
      2'd0:    return {{24{~uns & v[7]}}, v[7:0]};
      2'd1:    return {{16{~uns & v[15]}}, v[15:0]};
      default: return v;
    endcase
  endfunction

  // Beat 0 is built from the live op inputs in IDLE; later beats come from the latched op.
  always_comb begin
    if (state == IDLE) begin
      nxt_ld   = op_load;
      nxt_size = op_size;
      nxt_base = addr;
      nxt_wd   = wdata;
      nxt_k    = '0;
    end else begin
      nxt_ld   = load_l;
      nxt_size = size_l;
      nxt_base = addr_l;
      nxt_wd   = wdata_l;
      nxt_k    = beat + 3'd1;
    end
    nxt_addr  = nxt_base + ADDR_W'(32'(nxt_k) * BB);
    nxt_strb  = lane_en(nxt_size, nxt_k);
    nxt_wdata = nxt_ld ? '0 : lane_data(nxt_wd, nxt_size, nxt_k);
  end

  always_comb begin
    asm_next = asm_q;
    for (int unsigned j = 0; j < BB; j++) begin
      int unsigned b;
      b = 32'(beat) * BB + j;
      if (b < nbytes(size_l)) asm_next[8*b[1:0] +: 8] = mc_rdata[8*j +: 8];
    end
  end

  assign is_last = (beat == last_beat(size_l));
  assign trap    = TRAP_EN && ((op_size == 2'd1 && addr[0]) || (op_size[1] && addr[1:0] != 2'b00));
  assign stall_o = ~rst & req_valid & (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      load_l     <= 1'b0;
      uns_l      <= 1'b0;
      size_l     <= '0;
      addr_l     <= '0;
      wdata_l    <= '0;
      beat       <= '0;
      asm_q      <= '0;
      flushed    <= 1'b0;
      mc_req     <= 1'b0;
      mc_we      <= 1'b0;
      mc_addr    <= '0;
      mc_wdata   <= '0;
      mc_wstrb   <= '0;
      done_o     <= 1'b0;
      rdata_o    <= '0;
      misalign_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
          if (req_valid) begin
            load_l  <= op_load;
            uns_l   <= op_unsigned;
            size_l  <= op_size;
            addr_l  <= addr;
            wdata_l <= wdata;
            beat    <= '0;
            asm_q   <= '0;
            rdata_o <= '0;
            flushed <= 1'b0;
            if (trap) begin
              state      <= DONE;
              done_o     <= 1'b1;
              misalign_o <= 1'b1;
            end else begin
              state    <= REQ;
              mc_req   <= 1'b1;
              mc_we    <= ~nxt_ld;
              mc_addr  <= nxt_addr;
              mc_wdata <= nxt_wdata;
              mc_wstrb <= nxt_strb;
            end
          end
        end
        REQ: begin
          if (mc_ready) begin
            // An accepted read must still be waited out even if the op was flushed this cycle.
            if (load_l) begin
              state   <= WAIT;
              mc_req  <= 1'b0;
              flushed <= ~req_valid;
            end else if (!req_valid) begin
              state  <= IDLE;
              mc_req <= 1'b0;
            end else if (is_last) begin
              state  <= DONE;
              mc_req <= 1'b0;
              done_o <= 1'b1;
            end else begin
              beat     <= beat + 3'd1;
              mc_addr  <= nxt_addr;
              mc_wdata <= nxt_wdata;
              mc_wstrb <= nxt_strb;
            end
          end else if (!req_valid) begin
            state  <= IDLE;
            mc_req <= 1'b0;
          end
        end
        WAIT: begin
          if (!req_valid) flushed <= 1'b1;
          if (mc_rvalid) begin
            asm_q <= asm_next;
            if (flushed || !req_valid) begin
              state <= IDLE;
            end else if (is_last) begin
              state   <= DONE;
              done_o  <= 1'b1;
              rdata_o <= extend(asm_next, size_l, uns_l);
            end else begin
              state    <= REQ;
              beat     <= beat + 3'd1;
              mc_req   <= 1'b1;
              mc_we    <= 1'b0;
              mc_addr  <= nxt_addr;
              mc_wdata <= nxt_wdata;
              mc_wstrb <= nxt_strb;
            end
          end
        end
        DONE: begin
          done_o     <= 1'b0;
          misalign_o <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
